// File: rtl/dla_seq_fsm.sv
// dla_seq_fsm -- layer-sequencing controller for the DLA datapath.
//
// Walks FIRST_LOAD, then the compute phases CPB_0..CPB_{NUM_PH-1}, with a
// single LOADNEW phase placed before CPB_{LDNEW_POS}. Each working phase
// advances only on its own end flag. The sequence repeats for a latched
// number of rounds. Between rounds the controller either chains straight
// into the next round (auto) or parks in WAIT for a start instruction. A
// per-state watchdog forces a sticky ERR state when a phase overstays
// timeout_lim cycles.
//
// Ports
//   clk                 clock, posedge
//   rstn                synchronous active-low reset
//   start               start instruction, looked at in IDLE and WAIT only
//   auto                chain rounds without waiting for start
//   man_reset           synchronous soft reset back to IDLE
//   rounds              round count, latched when leaving IDLE (0 means 1)
//   timeout_lim         watchdog limit in cycles, 0 disables it
//   flag_firstload_end  FIRST_LOAD finished
//   flag_cpb_end        bit k: CPB_k finished
//   flag_ldnew_end      LOADNEW finished
//   busy                high outside IDLE and ERR
//   out_current_state   state register
//   out_prev_state      state before the most recent real transition
//   state_start         first cycle of a working-state entry
//   round_cnt           completed rounds
//   done                one-cycle pulse while in DONE
//   err                 high while in ERR
module dla_seq_fsm #(
  parameter int NUM_PH    = 5,
  parameter int LDNEW_POS = 3,
  parameter int ST_BITS   = 5,
  parameter int RND_BITS  = 8,
  parameter int TO_BITS   = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                auto,
  input  logic                man_reset,
  input  logic [RND_BITS-1:0] rounds,
  input  logic [TO_BITS-1:0]  timeout_lim,
  input  logic                flag_firstload_end,
  input  logic [NUM_PH-1:0]   flag_cpb_end,
  input  logic                flag_ldnew_end,
  output logic                busy,
  output logic [ST_BITS-1:0]  out_current_state,
  output logic [ST_BITS-1:0]  out_prev_state,
  output logic                state_start,
  output logic [RND_BITS-1:0] round_cnt,
  output logic                done,
  output logic                err
);

  // CPB states are numbered arithmetically, so only the fixed anchors are
  // named; intermediate compute states are reached by casting.
  typedef enum logic [ST_BITS-1:0] {
    S_IDLE       = ST_BITS'(0),
    S_FIRST_LOAD = ST_BITS'(1),
    S_LOADNEW    = ST_BITS'(2 + LDNEW_POS),
    S_LAST_CPB   = ST_BITS'(NUM_PH + 2),
    S_WAIT       = ST_BITS'(NUM_PH + 3),
    S_DONE       = ST_BITS'(NUM_PH + 4),
    S_ERR        = ST_BITS'(NUM_PH + 5)
  } state_t;

  function automatic logic [ST_BITS-1:0] cpb_state(input int k);
    return (k < LDNEW_POS) ? ST_BITS'(2 + k) : ST_BITS'(3 + k);
  endfunction

  state_t              st;
  state_t              nxt;
  logic [ST_BITS-1:0]  prev_st;
  logic [TO_BITS-1:0]  to_cnt;
  logic [RND_BITS-1:0] rnd_lim;
  logic                auto_q;
  logic                working;
  logic                nxt_working;
  logic                my_flag;
  logic                round_end;
  logic                timed_out;

  // Which end flag belongs to the current state; all others are ignored.
  always_comb begin
    my_flag = 1'b0;
    if (st == S_FIRST_LOAD) begin
      my_flag = flag_firstload_end;
    end else if (st == S_LOADNEW) begin
      my_flag = flag_ldnew_end;
    end else begin
      for (int k = 0; k < NUM_PH; k++) begin
        if (st == cpb_state(k)) my_flag = flag_cpb_end[k];
      end
    end
  end

  assign working     = (st  >= S_FIRST_LOAD) && (st  <= S_LAST_CPB);
  assign nxt_working = (nxt >= S_FIRST_LOAD) && (nxt <= S_LAST_CPB);
  assign timed_out   = (timeout_lim != '0) && (to_cnt == timeout_lim - TO_BITS'(1));

  // Next state: man_reset > flag advance > timeout > hold.
  always_comb begin
    nxt       = st;
    round_end = 1'b0;
    if (man_reset) begin
      nxt = S_IDLE;
    end else if (st == S_IDLE) begin
      if (start) nxt = S_FIRST_LOAD;
    end else if (st == S_WAIT) begin
      // auto_q lets a 0->1 edge of auto resume a parked sequence.
      if (start || (auto && !auto_q)) nxt = S_FIRST_LOAD;
    end else if (st == S_DONE) begin
      nxt = S_IDLE;
    end else if (st == S_ERR) begin
      nxt = S_ERR;
    end else if (working) begin
      if (my_flag) begin
        if (st == S_LAST_CPB) begin
          round_end = 1'b1;
          if (RND_BITS'(round_cnt + RND_BITS'(1)) == rnd_lim) nxt = S_DONE;
          else if (auto)                                        nxt = S_FIRST_LOAD;
          else                                                  nxt = S_WAIT;
        end else begin
          // Encoding is contiguous through LOADNEW, so the successor is +1.
          nxt = state_t'(st + ST_BITS'(1));
        end
      end else if (timed_out) begin
        nxt = S_ERR;
      end
    end else begin
      // Unused encodings fall back to IDLE.
      nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st          <= S_IDLE;
      prev_st     <= S_IDLE;
      state_start <= 1'b0;
      round_cnt   <= '0;
      rnd_lim     <= RND_BITS'(1);
      to_cnt      <= '0;
      auto_q      <= 1'b0;
    end else begin
      st          <= nxt;
      auto_q      <= auto;
      state_start <= (nxt != st) && nxt_working;
      if (man_reset) begin
        prev_st   <= S_IDLE;
        round_cnt <= '0;
        to_cnt    <= '0;
      end else begin
        if (nxt != st) prev_st <= st;
        // Counter reads 0 in the entry cycle of every working state.
        if ((nxt != st) || !working) to_cnt <= '0;
        else                         to_cnt <= to_cnt + TO_BITS'(1);
        if ((st == S_IDLE) && start) begin
          round_cnt <= '0;
          rnd_lim   <= (rounds == '0) ? RND_BITS'(1) : rounds;
        end else if (round_end) begin
          round_cnt <= round_cnt + RND_BITS'(1);
        end
      end
    end
  end

  assign out_current_state = st;
  assign out_prev_state    = prev_st;
  assign busy              = (st != S_IDLE) && (st != S_ERR);
  assign done              = (st == S_DONE);
  assign err               = (st == S_ERR);

endmodule

// File: tb/tb_dla_seq_fsm.sv
// Directed bench for dla_seq_fsm with default parameters
// (states: IDLE 0, FL 1, CPB0..2 = 2..4, LOADNEW 5, CPB3..4 = 6..7,
//  WAIT 8, DONE 9, ERR 10).
module tb_dla_seq_fsm;
  logic       clk = 1'b0;
  logic       rstn, start, auto, man_reset;
  logic [7:0] rounds;
  logic [9:0] timeout_lim;
  logic       ff, ld;
  logic [4:0] cpb;
  logic       busy, state_start, done, err;
  logic [4:0] cur, prev;
  logic [7:0] round_cnt;
  int         checks = 0;
  int         errors = 0;

  dla_seq_fsm dut (
    .clk(clk), .rstn(rstn), .start(start), .auto(auto), .man_reset(man_reset),
    .rounds(rounds), .timeout_lim(timeout_lim),
    .flag_firstload_end(ff), .flag_cpb_end(cpb), .flag_ldnew_end(ld),
    .busy(busy), .out_current_state(cur), .out_prev_state(prev),
    .state_start(state_start), .round_cnt(round_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stay dwell cycles in state s, raising its flag in the last one.
  task automatic phase(input int s, input int dwell);
    chk("phase_state", cur, s);
    if (dwell > 1) begin
      tick(dwell - 1);
      chk("phase_hold", cur, s);
    end
    case (s)
      1:       ff = 1'b1;
      5:       ld = 1'b1;
      2, 3, 4: cpb = 5'(1 << (s - 2));
      default: cpb = 5'(1 << (s - 3));
    endcase
    tick(1);
    ff = 1'b0; ld = 1'b0; cpb = '0;
  endtask

  task automatic run_round(input int dwell);
    for (int s = 1; s <= 7; s++) phase(s, dwell);
  endtask

  task automatic pulse_start;
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic soft_reset;
    man_reset = 1'b1; tick(1); man_reset = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; auto = 1'b0; man_reset = 1'b0;
    rounds = 8'd1; timeout_lim = '0; ff = 1'b0; ld = 1'b0; cpb = '0;
    tick(2);
    chk("rst_state", cur, 0);
    chk("rst_prev", prev, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ss", state_start, 0);
    chk("rst_rcnt", round_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;

    // Single round, flags 10 cycles after entry.
    tick(3);
    pulse_start;
    chk("r1_fl_ss", state_start, 1);
    chk("r1_busy", busy, 1);
    phase(1, 11);
    chk("r1_prev", prev, 1);
    chk("r1_ss_cpb0", state_start, 1);
    for (int s = 2; s <= 7; s++) phase(s, 11);
    chk("r1_done_state", cur, 9);
    chk("r1_done", done, 1);
    chk("r1_prev7", prev, 7);
    chk("r1_rcnt", round_cnt, 1);
    tick(1);
    chk("r1_idle", cur, 0);
    chk("r1_done_low", done, 0);
    chk("r1_busy_low", busy, 0);
    chk("r1_rcnt_hold", round_cnt, 1);

    // FIRST_LOAD follows start by one edge regardless of when it comes.
    for (int i = 0; i < 3; i++) begin
      int d;
      d = (i == 0) ? 3 : (i == 1) ? 4 : 7;
      rstn = 1'b0; tick(1); rstn = 1'b1;
      tick(d);
      chk("st_idle_before", cur, 0);
      pulse_start;
      chk("st_fl", cur, 1);
      soft_reset;
    end

    // Two rounds, manual restart from WAIT.
    rounds = 8'd2;
    pulse_start;
    run_round(2);
    chk("w_state", cur, 8);
    chk("w_rcnt", round_cnt, 1);
    chk("w_busy", busy, 1);
    tick(6);
    chk("w_hold", cur, 8);
    pulse_start;
    chk("w_fl", cur, 1);
    chk("w_ss", state_start, 1);
    run_round(1);
    chk("w_done", cur, 9);
    chk("w_rcnt2", round_cnt, 2);
    tick(1);

    // Rising auto releases WAIT.
    pulse_start;
    run_round(1);
    chk("wa_state", cur, 8);
    tick(2);
    auto = 1'b1; tick(1);
    chk("wa_fl", cur, 1);
    auto = 1'b0;
    soft_reset;

    // Three chained rounds.
    rounds = 8'd3; auto = 1'b1;
    pulse_start;
    run_round(1);
    chk("a_fl1", cur, 1);
    chk("a_ss1", state_start, 1);
    chk("a_rcnt1", round_cnt, 1);
    run_round(1);
    chk("a_fl2", cur, 1);
    chk("a_rcnt2", round_cnt, 2);
    run_round(1);
    chk("a_done", cur, 9);
    chk("a_rcnt3", round_cnt, 3);
    tick(1);
    chk("a_rcnt3_hold", round_cnt, 3);

    // rounds=0 behaves as one round, even with auto set.
    rounds = 8'd0;
    pulse_start;
    chk("z_rcnt_clr", round_cnt, 0);
    run_round(1);
    chk("z_done", cur, 9);
    chk("z_rcnt", round_cnt, 1);
    tick(1);
    auto = 1'b0; rounds = 8'd1;

    // Watchdog: CPB_2 never finishes.
    timeout_lim = 10'd5;
    pulse_start;
    phase(1, 1); phase(2, 1); phase(3, 1);
    chk("to_in4", cur, 4);
    tick(4);
    chk("to_hold4", cur, 4);
    tick(1);
    chk("to_err_state", cur, 10);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_prev", prev, 4);
    start = 1'b1; cpb = 5'b00100; tick(2); start = 1'b0; cpb = '0;
    chk("to_sticky", cur, 10);
    soft_reset;
    chk("to_mr_idle", cur, 0);
    chk("to_mr_err", err, 0);
    chk("to_mr_prev", prev, 0);

    // Flag on the final allowed cycle beats the timeout.
    pulse_start;
    phase(1, 5);
    chk("to_flag_wins", cur, 2);
    soft_reset;
    timeout_lim = '0;

    // Stray flags and start in CPB_1 are ignored.
    pulse_start;
    phase(1, 1); phase(2, 1);
    chk("sf_cpb1", cur, 3);
    cpb = 5'b01000; start = 1'b1; ff = 1'b1; ld = 1'b1;
    tick(3);
    cpb = '0; start = 1'b0; ff = 1'b0; ld = 1'b0;
    chk("sf_hold", cur, 3);
    phase(3, 1); phase(4, 1);
    chk("sf_ldnew", cur, 5);
    soft_reset;
    chk("sf_mr_idle", cur, 0);
    chk("sf_mr_rcnt", round_cnt, 0);

    // Hard reset in CPB_3.
    pulse_start;
    for (int s = 1; s <= 5; s++) phase(s, 1);
    chk("hr_cpb3", cur, 6);
    rstn = 1'b0; tick(1);
    chk("hr_state", cur, 0);
    chk("hr_prev", prev, 0);
    chk("hr_busy", busy, 0);
    chk("hr_ss", state_start, 0);
    chk("hr_rcnt", round_cnt, 0);
    chk("hr_done", done, 0);
    chk("hr_err", err, 0);
    rstn = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
